// File: rtl/fir_output_conditioner.sv
// fir_output_conditioner
//
// Output stage for the symmetric FIR. It requantizes the full-precision
// sample to OUTPUT_WIDTH bits with selectable rounding and optional
// saturation. It keeps one sample in every DECIM and buffers the results in a
// small FIFO behind a ready/valid handshake. The source has no backpressure,
// so a write into a full FIFO discards the sample and pulses drop.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   valid_in   in   din is valid this cycle
//   din        in   signed input sample, INPUT_WIDTH bits
//   sat_clr    in   synchronous clear of sat_flag
//   valid_out  out  FIFO not empty, dout valid
//   ready_in   in   downstream accepts dout when valid_out is also high
//   dout       out  signed output sample (FIFO head), OUTPUT_WIDTH bits
//   sat_flag   out  sticky: some sample written to the FIFO stage was clamped
//   drop       out  one-cycle pulse: a sample was discarded on a full FIFO
//
// Pipeline: din -> round -> stage 1 -> saturate -> stage 2 -> FIFO write.
// A kept sample sampled at edge k is visible on dout after edge k+2.

module fir_output_conditioner #(
    parameter int INPUT_WIDTH  = 26,
    parameter int OUTPUT_WIDTH = 16,
    parameter int ROUND_MODE   = 1,
    parameter int SATURATE     = 1,
    parameter int DECIM        = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [INPUT_WIDTH-1:0]  din,
    input  logic                    sat_clr,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic [OUTPUT_WIDTH-1:0] dout,
    output logic                    sat_flag,
    output logic                    drop
);

    localparam int SHIFT = INPUT_WIDTH - OUTPUT_WIDTH;
    localparam int XW    = INPUT_WIDTH + 1;   // extended working width
    localparam int RW    = OUTPUT_WIDTH + 1;  // rounded result always fits here
    localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = AW + 1;

    // ------------------------------------------------------------------
    // Rounding (combinational, ahead of stage 1)
    // ------------------------------------------------------------------
    logic signed [XW-1:0] din_ext;
    logic signed [RW-1:0] rounded;

    always_comb begin
        din_ext = {din[INPUT_WIDTH-1], din};
    end

    generate
        if (SHIFT == 0) begin : g_noshift
            always_comb begin
                rounded = din_ext;
            end
        end else begin : g_shift
            localparam logic [XW-1:0] ONE  = {{(XW-1){1'b0}}, 1'b1};
            localparam logic [XW-1:0] HALF = ONE << (SHIFT - 1);

            logic [XW-1:0]        bias;
            logic signed [XW-1:0] biased;
            logic signed [XW-1:0] shifted;
            logic                 unused_hi;

            always_comb begin
                case (ROUND_MODE)
                    0:       bias = '0;
                    // half - 1 + lsb-of-result: ties go to the even neighbour
                    2:       bias = HALF - ONE + {{(XW-1){1'b0}}, din[SHIFT]};
                    default: bias = HALF;
                endcase
                biased  = din_ext + $signed(bias);
                shifted = biased >>> SHIFT;
                // Upper bits are pure sign extension of the RW-bit result.
                rounded   = shifted[RW-1:0];
                unused_hi = ^shifted[XW-1:RW];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decimation phase
    // ------------------------------------------------------------------
    logic [PW-1:0] phase;
    logic          keep;

    always_comb begin
        keep = (phase == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (valid_in) begin
            if (phase == PW'(DECIM - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: rounded value
    // ------------------------------------------------------------------
    logic                 s1_valid;
    logic signed [RW-1:0] s1_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= valid_in && keep;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in && keep) begin
            s1_r <= rounded;
        end
    end

    // ------------------------------------------------------------------
    // Saturation: out of range when the two top bits of the RW-bit value
    // disagree.
    // ------------------------------------------------------------------
    logic [OUTPUT_WIDTH-1:0] sat_val;
    logic                    sat_hit;
    logic                    out_of_range;

    always_comb begin
        out_of_range = s1_r[RW-1] ^ s1_r[RW-2];
        sat_hit      = 1'b0;
        sat_val      = s1_r[OUTPUT_WIDTH-1:0];
        if ((SATURATE != 0) && out_of_range) begin
            sat_hit = 1'b1;
            sat_val = s1_r[RW-1] ? {1'b1, {(OUTPUT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturated value, presented to the FIFO write port
    // ------------------------------------------------------------------
    logic                    s2_valid;
    logic [OUTPUT_WIDTH-1:0] s2_data;
    logic                    s2_sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            s2_data <= sat_val;
            s2_sat  <= sat_hit;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [OUTPUT_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    overflow;

    always_comb begin
        empty    = (count == '0);
        full     = (count == CW'(FIFO_DEPTH));
        pop      = !empty && ready_in;
        // A pop frees the slot in the same cycle, so a full FIFO can still
        // accept the incoming sample.
        push     = s2_valid && (!full || pop);
        overflow = s2_valid && full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop     <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            drop <= overflow;
            // Set has priority over a simultaneous clear; a clamped sample
            // sets the flag even if it is then dropped.
            if (s2_valid && s2_sat) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s2_data;
        end
    end

    always_comb begin
        valid_out = !empty;
        dout      = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: tb/tb_fir_output_conditioner.sv
// Testbench for fir_output_conditioner.
// Five instances share one input stream:
//   0: truncate, 1: half-up, 2: convergent, 3: half-up with wrap,
//   4: half-up with DECIM=3.
// A sample-level model (integer rounding, delay of two edges, queue FIFO)
// is compared on every falling edge; directed sections add literal checks.

module tb_fir_output_conditioner;

    localparam int NI    = 5;
    localparam int IW    = 26;
    localparam int OW    = 16;
    localparam int DEPTH = 4;

    localparam int RM_A  [NI] = '{0, 1, 2, 1, 1};
    localparam int SAT_A [NI] = '{1, 1, 1, 0, 1};
    localparam int DEC_A [NI] = '{1, 1, 1, 1, 3};

    logic                 clk;
    logic                 rst_n;
    logic                 valid_in;
    logic signed [IW-1:0] din;
    logic                 sat_clr;
    logic                 ready_in;

    logic          vout   [NI];
    logic [OW-1:0] dout_w [NI];
    logic          satf   [NI];
    logic          drp    [NI];

    int n_chk  = 0;
    int n_fail = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fir_output_conditioner #(
            .INPUT_WIDTH (IW),
            .OUTPUT_WIDTH(OW),
            .ROUND_MODE  (RM_A[g]),
            .SATURATE    (SAT_A[g]),
            .DECIM       (DEC_A[g]),
            .FIFO_DEPTH  (DEPTH)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .valid_in (valid_in),
            .din      (din),
            .sat_clr  (sat_clr),
            .valid_out(vout[g]),
            .ready_in (ready_in),
            .dout     (dout_w[g]),
            .sat_flag (satf[g]),
            .drop     (drp[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint round_model(longint x, int mode);
        longint q;
        longint rem;
        q   = x >>> 10;          // floor(x / 1024)
        rem = x - q * 1024;
        case (mode)
            0:       return q;
            1:       return (rem >= 512) ? q + 1 : q;
            default: begin
                if (rem > 512) return q + 1;
                if (rem == 512) return q + (q & 1);
                return q;
            end
        endcase
    endfunction

    // {clamped, value}
    function automatic logic [OW:0] sat_model(longint r, int en);
        if (en != 0 && r > 32767)  return {1'b1, 16'h7FFF};
        if (en != 0 && r < -32768) return {1'b1, 16'h8000};
        return {1'b0, 16'(r)};
    endfunction

    int            m_phase [NI];
    bit            m_v1    [NI];
    longint        m_r1    [NI];
    bit            m_v2    [NI];
    logic [OW-1:0] m_d2    [NI];
    bit            m_s2    [NI];
    logic [OW-1:0] m_q     [NI][8];
    int            m_cnt   [NI];
    bit            m_sat   [NI];
    bit            m_drop  [NI];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_phase[i] = 0;
                m_v1[i]    = 0;
                m_v2[i]    = 0;
                m_cnt[i]   = 0;
                m_sat[i]   = 0;
                m_drop[i]  = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                bit          pop;
                logic [OW:0] sm;
                m_drop[i] = 0;
                pop = (m_cnt[i] > 0) && ready_in;
                if (pop) begin
                    for (int k = 0; k < 7; k++) m_q[i][k] = m_q[i][k+1];
                    m_cnt[i]--;
                end
                if (m_v2[i]) begin
                    if (m_cnt[i] < DEPTH) begin
                        m_q[i][m_cnt[i]] = m_d2[i];
                        m_cnt[i]++;
                    end else begin
                        m_drop[i] = 1;
                    end
                end
                if (m_v2[i] && m_s2[i]) m_sat[i] = 1;
                else if (sat_clr)       m_sat[i] = 0;
                m_v2[i] = m_v1[i];
                if (m_v1[i]) begin
                    sm      = sat_model(m_r1[i], SAT_A[i]);
                    m_s2[i] = sm[OW];
                    m_d2[i] = sm[OW-1:0];
                end
                m_v1[i] = valid_in && (m_phase[i] == 0);
                if (valid_in) begin
                    if (m_phase[i] == 0) m_r1[i] = round_model(longint'(din), RM_A[i]);
                    m_phase[i] = (m_phase[i] + 1) % DEC_A[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("valid_out[%0d]", i), vout[i], (m_cnt[i] > 0) ? 1 : 0);
            if (m_cnt[i] > 0) chk($sformatf("dout[%0d]", i), dout_w[i], m_q[i][0]);
            chk($sformatf("sat_flag[%0d]", i), satf[i], m_sat[i]);
            chk($sformatf("drop[%0d]", i), drp[i], m_drop[i]);
            if (!rst_n) chk($sformatf("dout_rst[%0d]", i), dout_w[i], 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic v, input logic signed [IW-1:0] d);
        @(negedge clk);
        valid_in = v;
        din      = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : stim
        int exp_r [3][3];
        int ct;
        int tfirst;
        int vals [3];
        int dtimes [4];

        exp_r = '{'{1, 2, -2}, '{2, 3, -1}, '{2, 2, -2}};
        rst_n    = 1'b0;
        valid_in = 1'b0;
        din      = '0;
        sat_clr  = 1'b0;
        ready_in = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid_out", vout[i], 0);
            chk("rst_dout", dout_w[i], 0);
            chk("rst_sat_flag", satf[i], 0);
            chk("rst_drop", drp[i], 0);
        end
        #2 rst_n = 1'b1;

        // Rounding in each mode
        ready_in = 1'b1;
        drive(1, 1536);
        drive(1, 2560);
        drive(1, -1536);
        for (int s = 0; s < 3; s++) begin
            drive(0, 0);
            for (int m = 0; m < 3; m++) begin
                chk("round_valid", vout[m], 1);
                chk($sformatf("round_m%0d_s%0d", m, s), $signed(dout_w[m]), exp_r[m][s]);
            end
        end
        repeat (3) drive(0, 0);

        // Saturation and wrap
        drive(1, 33554431);
        drive(1, 1024);
        drive(1, 2048);
        drive(0, 0);
        chk("sat_pos_dout", $signed(dout_w[1]), 32767);
        chk("sat_pos_flag", satf[1], 1);
        chk("wrap_dout", $signed(dout_w[3]), -32768);
        chk("wrap_flag", satf[3], 0);
        drive(0, 0);
        drive(0, 0);
        chk("sat_sticky", satf[1], 1);
        drive(0, 0);
        sat_clr = 1'b1;
        drive(0, 0);
        sat_clr = 1'b0;
        chk("sat_clr", satf[1], 0);
        drive(1, -33554432);
        repeat (3) drive(0, 0);
        chk("sat_neg_dout", $signed(dout_w[1]), -32768);
        chk("sat_neg_flag", satf[1], 0);
        repeat (3) drive(0, 0);

        // Decimation by 3
        do_reset();
        ready_in = 1'b1;
        ct = 0;
        tfirst = -1;
        for (int t = 0; t < 13; t++) begin
            if (t < 9) drive(1, t * 1024);
            else       drive(0, 0);
            if (vout[4]) begin
                if (tfirst < 0) tfirst = t;
                if (ct < 3) vals[ct] = int'($signed(dout_w[4]));
                ct++;
            end
        end
        chk("decim_count", ct, 3);
        chk("decim_first", tfirst, 3);
        chk("decim_v0", vals[0], 0);
        chk("decim_v1", vals[1], 3);
        chk("decim_v2", vals[2], 6);

        // Overflow with ready_in low
        do_reset();
        ready_in = 1'b0;
        ct = 0;
        for (int t = 0; t < 13; t++) begin
            if (t < 6) drive(1, (t + 1) * 1024);
            else       drive(0, 0);
            if (drp[1]) begin
                if (ct < 4) dtimes[ct] = t;
                ct++;
            end
        end
        chk("ovf_drop_count", ct, 2);
        chk("ovf_drop_t0", dtimes[0], 7);
        chk("ovf_drop_t1", dtimes[1], 8);
        @(negedge clk);
        ready_in = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (j < 4) begin
                chk("ovf_drain_valid", vout[1], 1);
                chk("ovf_drain_dout", $signed(dout_w[1]), j + 1);
            end else begin
                chk("ovf_drain_empty", vout[1], 0);
            end
            @(negedge clk);
        end

        // Full FIFO with simultaneous push and pop
        do_reset();
        ready_in = 1'b0;
        ct = 0;
        for (int t = 0; t < 13; t++) begin
            if (t < 5) drive(1, (t + 10) * 1024);
            else       drive(0, 0);
            ready_in = (t == 6);
            if (drp[1]) ct++;
        end
        chk("fullpp_no_drop", ct, 0);
        @(negedge clk);
        ready_in = 1'b1;
        for (int j = 0; j < 5; j++) begin
            if (j < 4) begin
                chk("fullpp_valid", vout[1], 1);
                chk("fullpp_dout", $signed(dout_w[1]), j + 11);
            end else begin
                chk("fullpp_empty", vout[1], 0);
            end
            @(negedge clk);
        end

        // Asynchronous reset mid-stream
        do_reset();
        ready_in = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (t == 0)     drive(1, 33554431);
            else if (t < 8) drive(1, t * 1024);
            else            drive(0, 0);
        end
        chk("pre_rst_drop", drp[1], 1);
        chk("pre_rst_valid", vout[4], 1);
        chk("pre_rst_sat", satf[4], 1);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("async_rst_valid", vout[i], 0);
            chk("async_rst_dout", dout_w[i], 0);
            chk("async_rst_sat", satf[i], 0);
            chk("async_rst_drop", drp[i], 0);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1, 5 * 1024);
        drive(0, 0);
        chk("post_rst_lat1", vout[4], 0);
        drive(0, 0);
        chk("post_rst_lat2", vout[4], 0);
        drive(0, 0);
        chk("post_rst_valid", vout[4], 1);
        chk("post_rst_dout", $signed(dout_w[4]), 5);
        repeat (3) drive(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_output_conditioner.md
# fir_output_conditioner

Output stage placed directly downstream of the symmetric FIR filter. It takes the filter's full-precision `dout`/`valid_out` stream and requantizes each sample to `OUTPUT_WIDTH` bits, with selectable rounding and optional saturation. It also applies integer decimation and buffers results in a small FIFO behind a ready/valid handshake. The FIR has no backpressure, so overflow of this FIFO drops samples and flags the drop.

## Interface

Parameters:
- `INPUT_WIDTH`, 26, width of the signed input sample (the FIR full-precision output).
- `OUTPUT_WIDTH`, 16, width of the signed output sample. Must be ≤ `INPUT_WIDTH`.
- `ROUND_MODE`, 1, rounding mode:
  - 0: truncate (floor).
  - 1: round half up (toward +inf).
  - 2: convergent (round half to even).
- `SATURATE`, 1, saturation control:
  - 1: clamp to the signed `OUTPUT_WIDTH` range.
  - 0: wrap (keep the low bits).
- `DECIM`, 1, decimation factor, ≥ 1.
- `FIFO_DEPTH`, 4, output FIFO entries. Power of two, ≥ 2.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `rst_n` in 1: reset. Asynchronous assert, active-low.
- `valid_in` in 1: `din` is valid this cycle. There is no ready back to the source.
- `din` in `INPUT_WIDTH`: signed input sample.
- `sat_clr` in 1: synchronous clear of `sat_flag`.
- `valid_out` out 1: FIFO not empty, so `dout` is valid.
- `ready_in` in 1: downstream accepts `dout` when both `valid_out` and `ready_in` are high.
- `dout` out `OUTPUT_WIDTH`: signed output sample (FIFO head).
- `sat_flag` out 1: sticky flag; some emitted sample was clamped.
- `drop` out 1: one-cycle pulse; a sample was discarded because the FIFO was full.

## Operation

Requantization arithmetic:
- Shift amount `S = INPUT_WIDTH - OUTPUT_WIDTH`.
- Work in `INPUT_WIDTH+1` bits, sign-extended, so the rounding add cannot overflow.
- Truncate: `r = din >>> S`.
- Half-up: `r = (din + 2^(S-1)) >>> S`.
- Convergent: `r = (din + 2^(S-1) - 1 + din[S]) >>> S`.
- When `S = 0`, `r = din` in every mode.

Saturation:
- If `r` is above `2^(OW-1)-1` or below `-2^(OW-1)`:
  - `SATURATE=1`: output is the clamped value and `sat_flag` is set.
  - `SATURATE=0`: output is the low `OW` bits of `r` and `sat_flag` is unaffected.

Decimation:
- A phase counter runs 0..`DECIM-1` and advances once per `valid_in`, wrapping to 0.
- Only the sample arriving at phase 0 is kept, so samples 0, D, 2D, … pass.
- Discarded samples have no other effect.

Pipeline:
- Stage 1 registers the rounded value `r` and a valid bit, gated by the decimation keep decision.
- Stage 2 saturates and writes the FIFO.

FIFO:
- `valid_out = !empty`; `dout` is the head entry.
- Pop: `valid_out && ready_in`.
- Push: stage-2 valid.
- Push while full:
  - If a pop happens in the same cycle, both proceed and the count is unchanged.
  - Otherwise the new sample is discarded and `drop` is high for that cycle.
- `ready_in` while empty has no effect.

Flags:
- `sat_flag` is set at the FIFO-write stage, including when the saturated sample is then dropped.
- If `sat_clr` and a new saturation occur in the same cycle, set wins.

Reset (`rst_n` low, at any time, including mid-stream):
- Cleared: phase counter, pipeline valid bits, FIFO pointers/count, `sat_flag`, `drop`.
- Outputs during reset: `valid_out=0`, `dout=0`, `sat_flag=0`, `drop=0`.
- Data pipeline registers need no reset, but the valid bits do.

## Timing

- Latency from `valid_in` sampled at edge k (kept sample, FIFO empty) to `valid_out=1` with `dout` valid: after edge k+2.
- Throughput: one sample per cycle in and out when `ready_in` is held high; the FIFO does not fill.
- Pop at edge k: the next entry, or `valid_out=0`, is visible after edge k.
- `drop` and the `sat_flag` set are registered and appear after the edge on which the FIFO write was attempted.
- `dout` is stable while `valid_out && !ready_in`.
- The first accepted sample after reset release has phase 0 and is kept.

## Test plan

- **Rounding**, IW=26, OW=16, S=10. Sweep `din` over 1536, 2560, -1536 in each mode:
  - `ROUND_MODE=0` -> `dout` = 1, 2, -2.
  - `ROUND_MODE=1` -> `dout` = 2, 3, -1.
  - `ROUND_MODE=2` -> `dout` = 2, 2, -2.
- **Saturation**, `ROUND_MODE=1`, `SATURATE=1`:
  - `din=2^25-1` -> `dout=0x7FFF`, `sat_flag` goes to 1 and stays after further in-range samples; `sat_clr` pulse -> 0.
  - `din=-2^25` -> `dout=0x8000`, `sat_flag` unchanged.
  - With `SATURATE=0`, `din=2^25-1` -> `dout=0x8000`, `sat_flag` stays 0.
- **Decimation**, `DECIM=3`, `din` = 0,1024,…,8×1024 on consecutive cycles, `ready_in=1` -> `dout` sequence 0, 3, 6 only; first `valid_out` two cycles after the first `valid_in`.
- **Backpressure/overflow**, `DECIM=1`, depth 4, `ready_in=0`, six samples 1..6 (×1024) -> `drop` pulses exactly twice, for samples 5 and 6. Raising `ready_in` then yields 1, 2, 3, 4 in order, then `valid_out=0`.
- **Full with simultaneous push/pop**: FIFO full, `ready_in=1` and `valid_in=1` in the same cycle -> no `drop`, count stays 4, order preserved.
- **Reset mid-stream**: assert `rst_n=0` asynchronously between edges with 3 entries held and phase=2 -> `valid_out`, `sat_flag`, `drop` fall immediately. After release, the next `valid_in` is kept (phase 0) and appears two edges later.
